screen_scanner: RTL and testbench
=================================

# screen_scanner

Raster read-out engine for the Hack screen map. It sits directly downstream of the Memory block and walks the 8K-word screen region (0x4000–0x5FFF) through Memory's combinational read path. It serializes each 16-bit word into single pixels on a ready/valid stream with line and frame markers, for consumption by a display driver or a frame-capture bench. It is read-only: it never asserts Memory's load.

## Interface
- BASE, 15'h4000, first screen word address
- WORDS_PER_ROW, 32, words per raster line (512 px)
- ROWS, 256, lines per frame
- clk  in  1  rising-edge clock shared with Memory
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- enable  in  1  start or continue frames; sampled only at frame boundaries
- mem_addr  out  15  word address to Memory address input
- mem_data  in  16  Memory out (combinational read of mem_addr)
- pixel  out  1  current pixel, 1 = black
- pixel_valid  out  1  pixel is presented
- pixel_ready  in  1  downstream accepts pixel this cycle
- line_start  out  1  current pixel is column 0 of a row
- frame_start  out  1  current pixel is row 0, column 0
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- States: IDLE, FETCH, SHIFT.
- IDLE: pixel_valid=0. On an edge with enable=1, go to FETCH with word index 0.
- FETCH (exactly 1 cycle): mem_addr = BASE + row*WORDS_PER_ROW + col. At the closing edge, shreg <= mem_data, bit count <= 0, go to SHIFT.
- SHIFT: pixel = shreg[0] (LSB is the leftmost pixel, per Hack convention), pixel_valid=1.
- Accept = pixel_valid & pixel_ready. On accept: shreg shifts right 1 and bit count increments.
- After the accept of bit 15: col increments. If col wraps past WORDS_PER_ROW-1, col=0 and row increments. Then go to FETCH.
- After the accept of bit 15 of the last word (row ROWS-1, col WORDS_PER_ROW-1): row and col clear, and frame_done is asserted next cycle. Go to FETCH if enable=1, otherwise IDLE.
- line_start = SHIFT & col==0 & bit==0. frame_start = line_start & row==0. Both are held for as long as that pixel stalls.
- Deasserting enable mid-frame has no effect; the frame always completes.
- pixel_ready while pixel_valid=0 is ignored.
- Address arithmetic is 15-bit. row is 8 bits, col 5 bits, bit 4 bits. No address outside BASE..BASE+8191 is ever driven with default parameters.

## Timing
- Reset (async, immediate): state=IDLE, row=col=bit=0, shreg=0, mem_addr=BASE. pixel, pixel_valid, line_start, frame_start and frame_done are all 0.
- Reset mid-frame aborts the frame. No frame_done is issued, and the next frame restarts at word 0.
- mem_addr is registered and stable for the whole FETCH cycle. In other states it holds the last fetched address.
- Per word with pixel_ready=1: 1 FETCH cycle plus 16 SHIFT cycles, i.e. 17 cycles.
- Per frame with pixel_ready=1: 8192*17 = 139264 cycles, from the IDLE→FETCH edge to the edge that raises frame_done.
- Back-to-back frames: FETCH of word 0 coincides with the frame_done cycle, giving no gap.
- Stall: while pixel_ready=0, pixel, pixel_valid, line_start, frame_start and mem_addr all hold.
- Memory writes to the word currently in shreg are not reflected until the next frame.

## Test plan
- Word 0x4000=16'h0001, rest 0, pixel_ready=1, enable pulse → first pixel 1 with frame_start=line_start=1, next 15 pixels 0; mem_addr=0x4000 during first FETCH, then 0x4001.
- Word 0x401F=16'h8000 and 0x4020=16'hFFFF → pixel 511 of row 0 = 1; line_start=1 on the first pixel of row 1, and row 1 columns 0–15 are all 1.
- Backpressure: drop pixel_ready for 3 cycles while pixel index 5 of 16'h0020 is presented → pixel=1, valid=1 held 4 cycles, then continues; the word still takes 17+3 cycles.
- Full frame, ready=1, enable held 1 → frame_done pulses exactly once 139264 cycles after start; the next cycle's pixel after FETCH carries frame_start; mem_addr wraps 0x5FFF→0x4000.
- Enable dropped mid-frame at word 100 → frame completes, frame_done pulses, state returns to IDLE with pixel_valid=0.
- Assert reset at word 0x4123, bit 7 → all outputs 0 immediately, mem_addr=0x4000; on release with enable=1, the scan restarts from 0x4000 and no frame_done is seen for the aborted frame.

Source files
------------

// File: rtl/screen_scanner_if.sv
//==============================================================================
// Module      : screen_scanner_if
// Description : Memory read port and pixel stream bundle for screen_scanner.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface screen_scanner_if;
  logic        enable;
  logic [14:0] mem_addr;
  logic [15:0] mem_data;
  logic        pixel;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        line_start;
  logic        frame_start;
  logic        frame_done;

  modport master (
    input  enable, mem_data, pixel_ready,
    output mem_addr, pixel, pixel_valid, line_start, frame_start, frame_done
  );

  modport slave (
    output enable, mem_data, pixel_ready,
    input  mem_addr, pixel, pixel_valid, line_start, frame_start, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/screen_scanner.sv
//==============================================================================
// Module      : screen_scanner
// Description : Walks the Hack screen map and serializes it into a pixel stream.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module screen_scanner #(
  parameter logic [14:0] BASE          = 15'h4000,
  parameter int          WORDS_PER_ROW = 32,
  parameter int          ROWS          = 256
) (
  input  wire logic         clk,
  input  wire logic         reset,
  screen_scanner_if.master  bus
);

  localparam logic [4:0]  c_last_col = 5'(WORDS_PER_ROW - 1);
  localparam logic [7:0]  c_last_row = 8'(ROWS - 1);
  localparam logic [14:0] c_row_pitch = 15'(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_row;
  logic [4:0]  r_col;
  logic [3:0]  r_bit;
  logic [15:0] r_shreg;
  logic [14:0] r_mem_addr;
  logic        r_valid;
  logic        r_line_start;
  logic        r_frame_start;
  logic        r_frame_done;

  logic        w_accept;
  logic        w_last_col;
  logic        w_last_word;
  logic [4:0]  w_next_col;
  logic [7:0]  w_next_row;
  logic [14:0] w_next_addr;

  // r_valid is only ever set in SHIFT, so ready outside SHIFT is ignored
  assign w_accept    = r_valid & bus.pixel_ready;
  assign w_last_col  = (r_col == c_last_col);
  assign w_last_word = w_last_col && (r_row == c_last_row);
  assign w_next_col  = w_last_col ? 5'd0 : r_col + 5'd1;
  assign w_next_row  = w_last_col ? r_row + 8'd1 : r_row;
  assign w_next_addr = BASE + 15'(w_next_row) * c_row_pitch + 15'(w_next_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= 8'd0;
      r_col         <= 5'd0;
      r_bit         <= 4'd0;
      r_shreg       <= 16'd0;
      r_mem_addr    <= BASE;
      r_valid       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_row      <= 8'd0;
            r_col      <= 5'd0;
            r_mem_addr <= BASE;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_shreg       <= bus.mem_data;
          r_bit         <= 4'd0;
          r_valid       <= 1'b1;
          r_line_start  <= (r_col == 5'd0);
          r_frame_start <= (r_col == 5'd0) && (r_row == 8'd0);
          r_state       <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_accept) begin
            r_shreg       <= {1'b0, r_shreg[15:1]};
            r_bit         <= r_bit + 4'd1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_bit == 4'hF) begin
              r_valid <= 1'b0;
              if (w_last_word) begin
                // enable is only looked at here, so a frame always completes
                r_row        <= 8'd0;
                r_col        <= 5'd0;
                r_frame_done <= 1'b1;
                if (bus.enable) begin
                  r_mem_addr <= BASE;
                  r_state    <= S_FETCH;
                end else begin
                  r_state    <= S_IDLE;
                end
              end else begin
                r_row      <= w_next_row;
                r_col      <= w_next_col;
                r_mem_addr <= w_next_addr;
                r_state    <= S_FETCH;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.pixel       = r_shreg[0];
  assign bus.pixel_valid = r_valid;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_screen_scanner.sv
//==============================================================================
// Module      : tb_screen_scanner
// Description : Directed self-checking bench for screen_scanner (16-row frame).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_screen_scanner;

  localparam int ROWS      = 16;
  localparam int FRAME_CYC = ROWS * 32 * 17;

  logic clk;
  logic reset;
  logic [15:0] mem [0:32767];
  int errors;
  int checks;
  int cyc;
  int fd_count;
  logic acc;

  screen_scanner_if bus ();

  screen_scanner #(
    .BASE          (15'h4000),
    .WORDS_PER_ROW (32),
    .ROWS          (ROWS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_data = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_done === 1'b1) fd_count++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    fd_count = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h4000] = 16'h0001;
    mem[15'h4002] = 16'h0020;
    mem[15'h401F] = 16'h8000;
    mem[15'h4020] = 16'hFFFF;

    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.pixel_ready = 1'b1;
    #2;
    check("rst_valid", 32'(bus.pixel_valid), 32'd0);
    check("rst_pixel", 32'(bus.pixel), 32'd0);
    check("rst_line",  32'(bus.line_start), 32'd0);
    check("rst_frame", 32'(bus.frame_start), 32'd0);
    check("rst_done",  32'(bus.frame_done), 32'd0);
    check("rst_addr",  32'(bus.mem_addr), 32'h4000);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("idle_valid", 32'(bus.pixel_valid), 32'd0);

    // frame 1: enable held until word 100, then dropped
    bus.enable = 1'b1;
    tick();
    cyc = 0;
    check("f1_fetch_addr",  32'(bus.mem_addr), 32'h4000);
    check("f1_fetch_valid", 32'(bus.pixel_valid), 32'd0);
    tick();
    check("f1_p0_pixel", 32'(bus.pixel), 32'd1);
    check("f1_p0_valid", 32'(bus.pixel_valid), 32'd1);
    check("f1_p0_line",  32'(bus.line_start), 32'd1);
    check("f1_p0_frame", 32'(bus.frame_start), 32'd1);
    acc = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      acc = acc | bus.pixel | bus.line_start | ~bus.pixel_valid;
    end
    check("f1_p1_15_zero", 32'(acc), 32'd0);
    tick();
    check("w1_fetch_addr",  32'(bus.mem_addr), 32'h4001);
    check("w1_fetch_valid", 32'(bus.pixel_valid), 32'd0);

    // backpressure on bit 5 of 16'h0020
    tick_to(40);
    check("bp_pixel", 32'(bus.pixel), 32'd1);
    check("bp_valid", 32'(bus.pixel_valid), 32'd1);
    bus.pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_pixel", 32'(bus.pixel), 32'd1);
      check("bp_hold_valid", 32'(bus.pixel_valid), 32'd1);
      check("bp_hold_addr",  32'(bus.mem_addr), 32'h4002);
    end
    bus.pixel_ready = 1'b1;
    tick();
    check("bp_next_pixel", 32'(bus.pixel), 32'd0);
    tick_to(53);
    check("bp_last_valid", 32'(bus.pixel_valid), 32'd1);
    tick();
    check("w3_fetch_addr",  32'(bus.mem_addr), 32'h4003);
    check("w3_fetch_valid", 32'(bus.pixel_valid), 32'd0);

    // row boundary
    tick_to(546);
    check("px511_pixel", 32'(bus.pixel), 32'd1);
    check("px511_valid", 32'(bus.pixel_valid), 32'd1);
    tick();
    check("w32_fetch_addr", 32'(bus.mem_addr), 32'h4020);
    tick();
    check("row1_line",  32'(bus.line_start), 32'd1);
    check("row1_frame", 32'(bus.frame_start), 32'd0);
    acc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      acc = acc & bus.pixel & bus.pixel_valid;
      if (i < 15) tick();
    end
    check("row1_c0_15_ones", 32'(acc), 32'd1);

    tick_to(1703);
    check("w100_addr", 32'(bus.mem_addr), 32'h4064);
    bus.enable = 1'b0;
    fd_count = 0;
    tick_to(FRAME_CYC + 2);
    check("f1_pre_done",  32'(bus.frame_done), 32'd0);
    check("f1_pre_valid", 32'(bus.pixel_valid), 32'd1);
    tick();
    check("f1_done",       32'(bus.frame_done), 32'd1);
    check("f1_done_valid", 32'(bus.pixel_valid), 32'd0);
    tick();
    tick();
    check("f1_done_once", 32'(fd_count), 32'd1);
    check("f1_idle_valid", 32'(bus.pixel_valid), 32'd0);
    check("f1_idle_addr",  32'(bus.mem_addr), 32'h41FF);

    // frame 2: enable held, back-to-back into frame 3
    bus.enable = 1'b1;
    fd_count = 0;
    tick();
    cyc = 0;
    check("f2_fetch_addr", 32'(bus.mem_addr), 32'h4000);
    tick_to(FRAME_CYC - 1);
    check("f2_pre_done", 32'(bus.frame_done), 32'd0);
    check("f2_last_addr", 32'(bus.mem_addr), 32'h41FF);
    tick();
    check("f2_done",       32'(bus.frame_done), 32'd1);
    check("f2_done_count", 32'(fd_count), 32'd1);
    check("f2_wrap_addr",  32'(bus.mem_addr), 32'h4000);
    check("f2_wrap_valid", 32'(bus.pixel_valid), 32'd0);
    tick();
    check("f3_p0_frame", 32'(bus.frame_start), 32'd1);
    check("f3_p0_pixel", 32'(bus.pixel), 32'd1);
    check("f3_p0_done",  32'(bus.frame_done), 32'd0);

    // abort frame 3 at word 0x123, bit 7
    tick_to(FRAME_CYC + 291 * 17 + 8);
    check("abort_addr",  32'(bus.mem_addr), 32'h4123);
    check("abort_valid", 32'(bus.pixel_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_rst_valid", 32'(bus.pixel_valid), 32'd0);
    check("abort_rst_pixel", 32'(bus.pixel), 32'd0);
    check("abort_rst_line",  32'(bus.line_start), 32'd0);
    check("abort_rst_frame", 32'(bus.frame_start), 32'd0);
    check("abort_rst_done",  32'(bus.frame_done), 32'd0);
    check("abort_rst_addr",  32'(bus.mem_addr), 32'h4000);
    tick();
    reset = 1'b0;
    fd_count = 0;
    tick();
    cyc = 0;
    check("restart_addr",  32'(bus.mem_addr), 32'h4000);
    check("restart_valid", 32'(bus.pixel_valid), 32'd0);
    tick();
    check("restart_frame", 32'(bus.frame_start), 32'd1);
    check("restart_pixel", 32'(bus.pixel), 32'd1);
    tick_to(FRAME_CYC - 1);
    check("restart_no_done", 32'(fd_count), 32'd0);
    tick();
    check("restart_done",       32'(bus.frame_done), 32'd1);
    check("restart_done_count", 32'(fd_count), 32'd1);
    bus.enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
